mux_select_sequencer: RTL

MUX_SELECT_SEQUENCER -- requirements
Module: mux_select_sequencer

---
 rtl/mux_select_sequencer_pkg.sv | 15 +
 rtl/mux_select_sequencer_chan_next.sv | 25 ++
 rtl/mux_select_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer.
package mux_select_sequencer_pkg;

  localparam int NUM_CH        = 4;
  localparam int DWELL_DEFAULT = 4;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mux_select_sequencer_chan_next.sv
// Finds the next enabled channel above cur (or at/above cur when inclusive).
// Combinational; lowest qualifying channel wins.
module mux_chan_next
  import mux_select_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [1:0]        cur,
  input  logic              inclusive,
  output logic [1:0]        nxt,
  output logic              found
);

  always_comb begin
    nxt   = 2'd0;
    found = 1'b0;
    // Walk downward so the last hit is the lowest qualifying channel.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((2'(i) > cur) || (inclusive && (2'(i) == cur)))) begin
        nxt   = 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Steps a 4:1 mux select through the enabled channels, holding each for DWELL
// settle cycles, then captures mux_y per channel and pulses sample_valid.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              mux_y,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [NUM_CH-1:0] sample,
  output logic              sample_valid
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] mask;

  logic [NUM_CH-1:0] srch_mask;
  logic [1:0]        srch_cur;
  logic              srch_incl;
  logic [1:0]        nxt;
  logic              found;

  // One search unit serves both the first-channel pick (from IDLE, on the
  // live ch_en) and the advance decision (from CAPTURE, on the latched mask).
  assign srch_incl = (state == IDLE);
  assign srch_mask = srch_incl ? ch_en : mask;
  assign srch_cur  = srch_incl ? 2'd0 : sel;

  mux_chan_next u_chan_next (
    .mask      (srch_mask),
    .cur       (srch_cur),
    .inclusive (srch_incl),
    .nxt       (nxt),
    .found     (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= 2'd0;
      cnt          <= '0;
      mask         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask   <= ch_en;
            sample <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            if (found) begin
              sel   <= nxt;
              state <= SETTLE;
            end else begin
              state        <= DONE;
              sample_valid <= 1'b1;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == DWELL_LAST) state <= CAPTURE;
        end
        CAPTURE: begin
          sample[sel] <= mux_y;
          if (found) begin
            sel   <= nxt;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            state        <= DONE;
            sample_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
